cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 118 +++++++++++
 tb/tb_cache_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: two-requester front end for a single-port cache. Requester 0
// (fetch) and requester 1 (load-store) compete for the cache. A winner is
// granted in IDLE or RESP and then owns the cache for LATCH, ACCESS and RESP.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN    request, write flag, byte address, write data
//   gntN                        combinational one-cycle accept pulse
//   doneN, rdataN               completion pulse, read data (valid with doneN)
//   busy                        high whenever not IDLE
//   cache_addr, cache_we,       registered address, write enable and write
//   cache_data_in                 data to the cache
//   cache_data_out              cache read data, valid one edge after access
module cache_arbiter #(
   parameter int unsigned FIXED_PRIO = 0,
   localparam int unsigned AW = 16,
   localparam int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          busy,
   output logic [AW-1:0] cache_addr,
   output logic          cache_we,
   output logic [DW-1:0] cache_data_in,
   input  logic [DW-1:0] cache_data_out
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LATCH  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       owner;      // 1 = requester 1 owns the current access
   logic       we_q;
   logic       last_gnt;   // requester granted most recently
   logic       pick0;
   logic       opp;
   logic       any_gnt;

   // Arbitration and next-state decode
   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      pick0     = 1'b0;
      opp       = !rst && ((state == IDLE) || (state == RESP));
      // Requester 0 wins alone, on fixed priority, or when 1 was granted last
      if (req0 && (!req1 || (FIXED_PRIO != 0) || last_gnt))
         pick0 = 1'b1;
      if (opp) begin
         gnt0 = req0 && pick0;
         gnt1 = req1 && !pick0;
      end
      any_gnt = gnt0 || gnt1;
      case (state)
         IDLE:    if (any_gnt) state_nxt = LATCH;
         LATCH:   state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = any_gnt ? LATCH : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, capture registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         we_q          <= 1'b0;
         last_gnt      <= 1'b1;
         cache_addr    <= '0;
         cache_data_in <= '0;
         cache_we      <= 1'b0;
         done0         <= 1'b0;
         done1         <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         // Write strobe exists only for the ACCESS cycle
         cache_we <= (state_nxt == ACCESS) && we_q;
         done0    <= (state_nxt == RESP) && !owner;
         done1    <= (state_nxt == RESP) && owner;
         if (any_gnt) begin
            owner         <= gnt1;
            last_gnt      <= gnt1;
            we_q          <= gnt1 ? we1 : we0;
            cache_addr    <= gnt1 ? addr1 : addr0;
            cache_data_in <= gnt1 ? wdata1 : wdata0;
         end
      end
   end

   // Cache read data arrives during RESP, so it is steered combinationally
   always_comb begin
      rdata0 = '0;
      rdata1 = '0;
      if (done0 && !we_q) rdata0 = cache_data_out;
      if (done1 && !we_q) rdata1 = cache_data_out;
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: bench for cache_arbiter with a behavioural cache, a
// transaction-level reference model checked every cycle, and directed cases.
module tb_cache_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, busy, cache_we;
   logic [7:0]  rdata0, rdata1, cache_data_in;
   logic [15:0] cache_addr;
   logic [7:0]  cache_data_out = 8'h00;

   logic        b_req0, b_req1;
   logic        b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_cache_we;
   logic [7:0]  b_rdata0, b_rdata1, b_cache_data_in;
   logic [15:0] b_cache_addr;

   cache_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .cache_addr(cache_addr),
      .cache_we(cache_we), .cache_data_in(cache_data_in),
      .cache_data_out(cache_data_out));

   cache_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
      .addr0(16'h0040), .addr1(16'h0041), .wdata0(8'h00), .wdata1(8'h00),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
      .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
      .cache_addr(b_cache_addr), .cache_we(b_cache_we),
      .cache_data_in(b_cache_data_in), .cache_data_out(8'h00));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Power-up content of every cache byte
   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Behavioural cache: registered read, write on cache_we edges
   logic [7:0] cmem [logic [15:0]];
   int         we_edges = 0;
   always @(posedge clk) begin
      logic [7:0] rd;
      rd = cmem.exists(cache_addr) ? cmem[cache_addr] : init_val(cache_addr);
      if (cache_we) begin
         cmem[cache_addr] = cache_data_in;
         we_edges++;
      end
      cache_data_out <= rd;
   end

   // Reference model: one transaction in flight, done three cycles after grant
   logic [7:0]  rmem [logic [15:0]];
   int          cyc = 0;
   bit          m_busy = 1'b0;
   bit          m_owner, m_we;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   int          m_gcyc;
   bit          m_last = 1'b1;
   logic [15:0] m_caddr = 16'h0;
   int          dut_gnts = 0;
   int          dut_dones = 0;

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return rmem.exists(a) ? rmem[a] : init_val(a);
   endfunction

   always @(negedge clk) begin : cmp
      int         age;
      bit         e_g0, e_g1, e_d0, e_d1, e_we, opp;
      logic [7:0] e_r0, e_r1;
      cyc++;
      if (rst) begin
         // A write whose access edge already passed has reached the cache
         if (m_busy && m_we && (cyc - m_gcyc) >= 3) rmem[m_addr] = m_wdata;
         m_busy = 1'b0; m_last = 1'b1; m_caddr = 16'h0;
         dut_gnts = 0; dut_dones = 0;
         check("rst_gnt0", 32'(gnt0), 0);
         check("rst_gnt1", 32'(gnt1), 0);
         check("rst_done0", 32'(done0), 0);
         check("rst_done1", 32'(done1), 0);
         check("rst_rdata0", 32'(rdata0), 0);
         check("rst_rdata1", 32'(rdata1), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_cache_we", 32'(cache_we), 0);
         check("rst_cache_addr", 32'(cache_addr), 0);
      end else begin
         age  = m_busy ? cyc - m_gcyc : 0;
         e_d0 = m_busy && age == 3 && !m_owner;
         e_d1 = m_busy && age == 3 && m_owner;
         e_r0 = (e_d0 && !m_we) ? ref_rd(m_addr) : 8'h00;
         e_r1 = (e_d1 && !m_we) ? ref_rd(m_addr) : 8'h00;
         e_we = m_busy && age == 2 && m_we;
         opp  = !m_busy || age == 3;
         e_g0 = 1'b0; e_g1 = 1'b0;
         if (opp && req0 && req1) begin
            if (m_last) e_g0 = 1'b1; else e_g1 = 1'b1;
         end else if (opp) begin
            e_g0 = req0; e_g1 = req1;
         end
         check("gnt0", 32'(gnt0), 32'(e_g0));
         check("gnt1", 32'(gnt1), 32'(e_g1));
         check("done0", 32'(done0), 32'(e_d0));
         check("done1", 32'(done1), 32'(e_d1));
         check("rdata0", 32'(rdata0), 32'(e_r0));
         check("rdata1", 32'(rdata1), 32'(e_r1));
         check("busy", 32'(busy), 32'(m_busy));
         check("cache_we", 32'(cache_we), 32'(e_we));
         check("cache_addr", 32'(cache_addr), 32'(m_caddr));
         if (m_busy && m_we) check("cache_data_in", 32'(cache_data_in), 32'(m_wdata));
         dut_gnts  += int'(gnt0) + int'(gnt1);
         dut_dones += int'(done0) + int'(done1);
         if (m_busy && age == 3) begin
            if (m_we) rmem[m_addr] = m_wdata;
            m_busy = 1'b0;
         end
         if (e_g0 || e_g1) begin
            m_busy  = 1'b1;
            m_owner = e_g1;
            m_we    = e_g1 ? we1 : we0;
            m_addr  = e_g1 ? addr1 : addr0;
            m_wdata = e_g1 ? wdata1 : wdata0;
            m_gcyc  = cyc;
            m_last  = e_g1;
            m_caddr = m_addr;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction for requester `who`; lat = negedges from grant to done
   task automatic do_txn(input bit who, input bit we, input logic [15:0] a,
                         input logic [7:0] d, output logic [7:0] rd, output int lat);
      int n;
      bit g, dn;
      rd = 8'h00; lat = -1;
      if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      n = 0;
      do begin
         @(negedge clk); n++;
         g = who ? gnt1 : gnt0;
      end while (!g && n < 50);
      check("txn_granted", 32'(g), 1);
      tick();
      if (who) req1 = 1'b0; else req0 = 1'b0;
      if (!g) return;
      n = 0;
      do begin
         @(negedge clk); n++;
         dn = who ? done1 : done0;
      end while (!dn && n < 10);
      if (dn) begin
         lat = n;
         rd  = who ? rdata1 : rdata0;
      end
   endtask

   logic [7:0] exp_b2b [4] = '{8'h3D, 8'h3E, 8'h3F, 8'h38};

   initial begin
      logic [7:0]  rd;
      int          lat, n, k, nd, cnt0, cnt1, we_snap, d0_cnt;
      bit          g_prev;
      int          tie_who [$];
      int          tie_cyc [$];
      int          done_c [4];
      logic [7:0]  done_d [4];
      bit          pend [2];
      bit          r_got [2];
      bit          r_we [2];
      logic [15:0] r_addr [2];
      logic [7:0]  r_wd [2];

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0;
      b_req0 = 1'b0; b_req1 = 1'b0;
      repeat (3) @(posedge clk);

      // Tie from reset: round-robin order 0,1,0,1 every three cycles
      #1;
      req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0100; addr1 = 16'h0200; rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (gnt0) begin tie_who.push_back(0); tie_cyc.push_back(i); end
         if (gnt1) begin tie_who.push_back(1); tie_cyc.push_back(i); end
      end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      check("tie_grant_count", 32'(tie_who.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < tie_who.size()) begin
            check("tie_order", 32'(tie_who[i]), 32'(i % 2));
            check("tie_spacing", 32'(tie_cyc[i]), 32'(3 * i));
         end
      end
      repeat (4) tick();

      // Write then read back through requester 1
      do_txn(1'b1, 1'b1, 16'h0010, 8'hA5, rd, lat);
      check("wr_latency", 32'(lat), 3);
      do_txn(1'b1, 1'b0, 16'h0010, 8'h00, rd, lat);
      check("rd_latency", 32'(lat), 3);
      check("rd_data_a5", 32'(rd), 32'h0000_00A5);
      repeat (2) tick();

      // Back-to-back reads 0x0001..0x0004 with req0 held
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
      check("b2b_first_gnt", 32'(gnt0), 1);
      k = 1; nd = 0; g_prev = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (g_prev) begin
            if (k < 4) addr0 = 16'(k + 1);
            else req0 = 1'b0;
         end
         @(negedge clk);
         check("b2b_busy", 32'(busy), 1);
         g_prev = gnt0;
         if (gnt0) k++;
         if (done0 && nd < 4) begin done_c[nd] = c; done_d[nd] = rdata0; nd++; end
      end
      req0 = 1'b0;
      check("b2b_done_count", 32'(nd), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < nd) begin
            check("b2b_done_cycle", 32'(done_c[i]), 32'(3 * (i + 1)));
            check("b2b_rdata", 32'(done_d[i]), 32'(exp_b2b[i]));
         end
      end
      repeat (2) tick();

      // Reset during LATCH of a write: no cache write, no done, old data kept
      we_snap = we_edges;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 8'h5A;
      n = 0;
      do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
      check("rstw_gnt", 32'(gnt0), 1);
      tick();
      rst = 1'b1; req0 = 1'b0;
      tick();
      rst = 1'b0;
      d0_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         d0_cnt += int'(done0);
      end
      check("rstw_no_done", 32'(d0_cnt), 0);
      check("rstw_no_cache_we", 32'(we_edges - we_snap), 0);
      tick();
      do_txn(1'b0, 1'b0, 16'h0020, 8'h00, rd, lat);
      check("rstw_read_latency", 32'(lat), 3);
      check("rstw_read_prior", 32'(rd), 32'h0000_001C);
      repeat (2) tick();

      // Randomised traffic with occasional abandoned requests and resets
      pend[0] = 1'b0; pend[1] = 1'b0; r_got[0] = 1'b0; r_got[1] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 299) == 0) rst = 1'b1;
         for (int r = 0; r < 2; r++) begin
            if (r_got[r]) pend[r] = 1'b0;
            if (pend[r] && $urandom_range(0, 39) == 0) pend[r] = 1'b0;
            else if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r]   = 1'b1;
               r_we[r]   = 1'($urandom_range(0, 1));
               r_addr[r] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
               r_wd[r]   = 8'($urandom);
            end
         end
         req0 = pend[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wd[0];
         req1 = pend[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wd[1];
         @(negedge clk);
         r_got[0] = gnt0; r_got[1] = gnt1;
      end
      tick();
      req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
      repeat (6) tick();
      check("gnt_done_balance", 32'(dut_dones), 32'(dut_gnts));

      // Fixed priority: only requester 0 served until it drops
      b_req0 = 1'b1; b_req1 = 1'b1;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         cnt0 += int'(b_gnt0);
         cnt1 += int'(b_gnt1);
      end
      check("fp_gnt0_count", 32'(cnt0), 10);
      check("fp_gnt1_count", 32'(cnt1), 0);
      tick();
      b_req0 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_gnt1 && n < 10);
      check("fp_req1_served", 32'(b_gnt1), 1);
      check("fp_req1_wait", 32'(n), 1);
      tick();
      b_req1 = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
